// File: rtl/i_buf_pingpong_ctrl.sv
// Packs pixels into BRAM words and writes them into two ping-pong line banks,
// with a flushed partial last word, per-line interrupt, overflow and truncation flags.
module i_buf_pingpong_ctrl #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_WORD = 4,
  parameter int ADDRESS_WIDTH   = 12
) (
  input  logic                                   pclk,
  input  logic                                   reset_n,
  input  logic                                   vsync,
  input  logic                                   vde,
  input  logic [PIXEL_WIDTH-1:0]                 i_data,
  input  logic                                   line_ack,
  output logic                                   we,
  output logic [PIXELS_PER_WORD-1:0]             be,
  output logic [ADDRESS_WIDTH-1:0]               addr,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] o_data,
  output logic                                   line_irq,
  output logic                                   line_bank,
  output logic [ADDRESS_WIDTH-1:0]               line_words,
  output logic [1:0]                             bank_full,
  output logic                                   frame_start,
  output logic                                   overflow,
  output logic                                   truncated
);

  localparam int DATA_WIDTH = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int BANK_WORDS = 2 ** (ADDRESS_WIDTH - 1);
  localparam int LANE_W     = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DROP, FLUSH} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_wr_bank, r_rd_bank;
  logic [LANE_W-1:0]        r_lane;
  logic [ADDRESS_WIDTH-1:0] r_word_idx;
  logic [DATA_WIDTH-1:0]    r_pack, w_pack_nxt;
  logic                     r_pend, r_irq_pend, r_vsync_d;

  logic                       w_capture, w_drop_start, w_flush, w_lane_last;
  logic                       w_room, w_partial, w_ack, w_vsync_rise;
  logic [1:0]                 w_bank_full_nxt;
  logic [PIXELS_PER_WORD-1:0] w_part_be;

  // State register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (vde) w_state_nxt = bank_full[r_wr_bank] ? DROP : FILL;
      FILL:    if (!vde) w_state_nxt = FLUSH;
      DROP:    if (!vde) w_state_nxt = IDLE;
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: strobes consumed by the registered datapath
  always_comb begin
    w_capture    = vde && ((r_state == IDLE && !bank_full[r_wr_bank]) || r_state == FILL);
    w_drop_start = vde && r_state == IDLE && bank_full[r_wr_bank];
    w_flush      = (r_state == FLUSH);
    w_lane_last  = (r_lane == LANE_W'(PIXELS_PER_WORD - 1));
    w_room       = (r_word_idx < ADDRESS_WIDTH'(BANK_WORDS));
    w_partial    = (r_lane != '0);
    w_ack        = line_ack && (bank_full != 2'b00);
    w_vsync_rise = vsync && !r_vsync_d;
    w_part_be    = ~({PIXELS_PER_WORD{1'b1}} >> r_lane);

    // A new word starts from zero so unfilled lanes of a flushed word read as 0.
    w_pack_nxt = (r_lane == '0) ? '0 : r_pack;
    for (int k = 0; k < PIXELS_PER_WORD; k++) begin
      if (r_lane == LANE_W'(k))
        w_pack_nxt[DATA_WIDTH-1-k*PIXEL_WIDTH -: PIXEL_WIDTH] = i_data;
    end

    // Ack always targets rd_bank and completion wr_bank; they never collide.
    w_bank_full_nxt = bank_full;
    if (w_ack)   w_bank_full_nxt[r_rd_bank] = 1'b0;
    if (w_flush) w_bank_full_nxt[r_wr_bank] = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_lane      <= '0;
      r_word_idx  <= '0;
      r_pack      <= '0;
      r_pend      <= 1'b0;
      r_irq_pend  <= 1'b0;
      r_vsync_d   <= 1'b0;
      we          <= 1'b0;
      be          <= '0;
      addr        <= '0;
      o_data      <= '0;
      line_irq    <= 1'b0;
      line_bank   <= 1'b0;
      line_words  <= '0;
      bank_full   <= 2'b00;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      truncated   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every read sees the pre-edge value.
      we          <= 1'b0;
      line_irq    <= r_irq_pend;
      r_irq_pend  <= 1'b0;
      r_vsync_d   <= vsync;
      frame_start <= w_vsync_rise;
      r_pend      <= w_capture && w_lane_last;
      bank_full   <= w_bank_full_nxt;

      if (w_ack) r_rd_bank <= ~r_rd_bank;

      if (w_capture) begin
        r_pack <= w_pack_nxt;
        r_lane <= w_lane_last ? '0 : r_lane + LANE_W'(1);
      end

      // Word completed on the previous edge: write it, or discard once the bank is full.
      if (r_pend) begin
        if (w_room) begin
          we         <= 1'b1;
          be         <= '1;
          addr       <= {r_wr_bank, r_word_idx[ADDRESS_WIDTH-2:0]};
          o_data     <= r_pack;
          r_word_idx <= r_word_idx + ADDRESS_WIDTH'(1);
        end else begin
          truncated  <= 1'b1;
        end
      end

      if (w_flush) begin
        if (w_partial && w_room) begin
          we         <= 1'b1;
          be         <= w_part_be;
          addr       <= {r_wr_bank, r_word_idx[ADDRESS_WIDTH-2:0]};
          o_data     <= r_pack;
          line_words <= r_word_idx + ADDRESS_WIDTH'(1);
        end else begin
          line_words <= r_word_idx;
        end
        if (w_partial && !w_room) truncated <= 1'b1;
        line_bank  <= r_wr_bank;
        r_wr_bank  <= ~r_wr_bank;
        r_word_idx <= '0;
        r_lane     <= '0;
        r_irq_pend <= 1'b1;
      end

      if (w_drop_start) overflow <= 1'b1;

      // Frame start clears the sticky flags, taking priority over a same-cycle set.
      if (w_vsync_rise) begin
        overflow  <= 1'b0;
        truncated <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i_buf_pingpong_ctrl.sv
// Directed bench for i_buf_pingpong_ctrl with PIXEL_WIDTH=8, PIXELS_PER_WORD=4, ADDRESS_WIDTH=4.
module tb_i_buf_pingpong_ctrl;

  localparam int PW  = 8;
  localparam int PPW = 4;
  localparam int AW  = 4;
  localparam int DW  = PW * PPW;

  logic           pclk = 1'b0;
  logic           reset_n, vsync, vde, line_ack;
  logic [PW-1:0]  i_data;
  logic           we, line_irq, line_bank, frame_start, overflow, truncated;
  logic [PPW-1:0] be;
  logic [AW-1:0]  addr, line_words;
  logic [DW-1:0]  o_data;
  logic [1:0]     bank_full;

  i_buf_pingpong_ctrl #(.PIXEL_WIDTH(PW), .PIXELS_PER_WORD(PPW), .ADDRESS_WIDTH(AW)) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .vde(vde), .i_data(i_data),
    .line_ack(line_ack), .we(we), .be(be), .addr(addr), .o_data(o_data),
    .line_irq(line_irq), .line_bank(line_bank), .line_words(line_words),
    .bank_full(bank_full), .frame_start(frame_start), .overflow(overflow),
    .truncated(truncated)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    logic [PPW-1:0] be;
    int             cyc;
  } wr_t;

  wr_t          wq[$];
  int           cyc = 0;
  int           irq_cnt = 0;
  int           irq_cyc = 0;
  logic         irq_bank;
  logic [AW-1:0] irq_words;
  int           checks = 0;
  int           failures = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Log bus activity away from the active edge.
  always @(negedge pclk) begin
    if (we) wq.push_back('{a: addr, d: o_data, be: be, cyc: cyc});
    if (line_irq) begin
      irq_cnt++;
      irq_cyc   = cyc;
      irq_bank  = line_bank;
      irq_words = line_words;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [PPW-1:0] b);
    if (idx < wq.size()) begin
      check({tag, "_addr"}, 64'(wq[idx].a), 64'(a));
      check({tag, "_data"}, 64'(wq[idx].d), 64'(d));
      check({tag, "_be"},   64'(wq[idx].be), 64'(b));
    end else begin
      check({tag, "_present"}, 64'(wq.size()), 64'(idx + 1));
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_line(input logic [PW-1:0] base, input int n, input bit ack_at_flush);
    for (int i = 0; i < n; i++) begin
      vde    = 1'b1;
      i_data = base + PW'(i);
      @(posedge pclk); #1;
    end
    vde    = 1'b0;
    i_data = '0;
    @(posedge pclk); #1;
    if (ack_at_flush) line_ack = 1'b1;
    @(posedge pclk); #1;
    line_ack = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
  endtask

  task automatic pulse_ack();
    line_ack = 1'b1;
    @(posedge pclk); #1;
    line_ack = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vde = 1'b0; vsync = 1'b0; line_ack = 1'b0; i_data = '0;
    repeat (2) @(posedge pclk);
    #1 reset_n = 1'b1;
    @(posedge pclk); #1;
    wq.delete();
  endtask

  int n_irq;

  initial begin
    reset_n = 1'b0; vsync = 1'b0; vde = 1'b0; line_ack = 1'b0; i_data = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_outputs",
          64'({we, be, addr, o_data, line_irq, line_bank, line_words, bank_full,
               frame_start, overflow, truncated}), 64'(0));
    reset_n = 1'b1;
    @(posedge pclk); #1;

    // Asynchronous reset in the middle of a line, right while a write is on the bus.
    for (int i = 0; i < 5; i++) begin
      vde = 1'b1; i_data = 8'h11 + 8'(i);
      @(posedge pclk); #1;
    end
    check("midline_we_before_reset", 64'(we), 64'(1));
    #1 reset_n = 1'b0;
    #1;
    check("midline_reset_outputs",
          64'({we, be, addr, o_data, line_irq, line_bank, line_words, bank_full,
               frame_start, overflow, truncated}), 64'(0));
    vde = 1'b0;
    @(posedge pclk); #1;
    reset_n = 1'b1;
    @(posedge pclk); #1;
    wq.delete();

    // Exact fill: two full words into bank 0.
    n_irq = irq_cnt;
    send_line(8'h01, 8, 1'b0);
    check("exact_nwrites", 64'(wq.size()), 64'(2));
    check_wr("exact_w0", 0, 4'h0, 32'h01020304, 4'hF);
    check_wr("exact_w1", 1, 4'h1, 32'h05060708, 4'hF);
    check("exact_irq", 64'(irq_cnt - n_irq), 64'(1));
    check("exact_line_bank", 64'(irq_bank), 64'(0));
    check("exact_line_words", 64'(irq_words), 64'(2));
    check("exact_bank_full", 64'(bank_full), 64'(2'b01));

    // Partial flush: last word carries two lanes.
    do_reset();
    send_line(8'hA0, 6, 1'b0);
    check("partial_nwrites", 64'(wq.size()), 64'(2));
    check_wr("partial_w0", 0, 4'h0, 32'hA0A1A2A3, 4'hF);
    check_wr("partial_w1", 1, 4'h1, 32'hA4A50000, 4'hC);
    check("partial_line_words", 64'(line_words), 64'(2));
    if (wq.size() == 2) check("partial_irq_latency", 64'(irq_cyc - wq[1].cyc), 64'(1));

    // Ping-pong and overflow.
    do_reset();
    n_irq = irq_cnt;
    send_line(8'h10, 4, 1'b0);
    send_line(8'h20, 4, 1'b0);
    check_wr("pp_line1", 0, 4'h0, 32'h10111213, 4'hF);
    check_wr("pp_line2", 1, 4'h8, 32'h20212223, 4'hF);
    check("pp_bank_full", 64'(bank_full), 64'(2'b11));
    send_line(8'h30, 4, 1'b0);
    check("ovf_no_write", 64'(wq.size()), 64'(2));
    check("ovf_irq_count", 64'(irq_cnt - n_irq), 64'(2));
    check("ovf_flag", 64'(overflow), 64'(1));
    vsync = 1'b1;
    @(posedge pclk); #1;
    check("vsync_frame_start", 64'(frame_start), 64'(1));
    check("vsync_clears_ovf", 64'(overflow), 64'(0));
    @(posedge pclk); #1;
    check("frame_start_one_cycle", 64'(frame_start), 64'(0));
    vsync = 1'b0;
    check("vsync_keeps_banks", 64'(bank_full), 64'(2'b11));

    // Ack ordering: oldest bank (0) is released first.
    pulse_ack();
    check("ack_clears_bank0", 64'(bank_full), 64'(2'b10));
    wq.delete();
    send_line(8'hC0, 4, 1'b0);
    check_wr("ack_line", 0, 4'h0, 32'hC0C1C2C3, 4'hF);
    check("ack_line_bank", 64'(irq_bank), 64'(0));
    check("ack_bank_full", 64'(bank_full), 64'(2'b11));
    pulse_ack();
    check("ack_clears_bank1", 64'(bank_full), 64'(2'b01));
    wq.delete();
    send_line(8'hD0, 5, 1'b1);
    check_wr("coinc_w0", 0, 4'h8, 32'hD0D1D2D3, 4'hF);
    check_wr("coinc_w1", 1, 4'h9, 32'hD4000000, 4'h8);
    check("coinc_bank_full", 64'(bank_full), 64'(2'b10));
    check("coinc_line_bank", 64'(irq_bank), 64'(1));
    pulse_ack();
    check("coinc_then_ack", 64'(bank_full), 64'(2'b00));

    // Truncation: 40 pixels into an 8-word bank.
    do_reset();
    send_line(8'h00, 40, 1'b0);
    check("trunc_nwrites", 64'(wq.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(4 * i);
      check_wr("trunc_w", i, AW'(i), {b, b + 8'd1, b + 8'd2, b + 8'd3}, 4'hF);
    end
    check("trunc_flag", 64'(truncated), 64'(1));
    check("trunc_line_words", 64'(line_words), 64'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_buf_pingpong_ctrl.md
# i_buf_pingpong_ctrl

Parametrised successor to the single-line image buffer writer. It packs PIXELS_PER_WORD pixels of PIXEL_WIDTH bits into BRAM words and writes them into one of two ping-pong line banks with per-lane byte enables, including a flushed partial last word. The host DMA can drain one line while the next line fills. It sits between the video timing/pixel source and the AXI BRAM port. It raises a per-line interrupt carrying the bank and word count, and flags overflow and truncation.

## Interface
- PIXEL_WIDTH, 8, bits per pixel
- PIXELS_PER_WORD, 4, pixels packed per BRAM word (≥1); DATA_WIDTH = PIXEL_WIDTH*PIXELS_PER_WORD (derived)
- ADDRESS_WIDTH, 12, BRAM word address width; MSB selects bank; BANK_WORDS = 2^(ADDRESS_WIDTH-1)

- pclk  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  vertical sync, active high
- vde  in  1  video data enable, high for active pixels
- i_data  in  PIXEL_WIDTH  pixel, sampled when vde=1
- line_ack  in  1  one-cycle pulse: host has drained the oldest full bank
- we  out  1  BRAM write enable
- be  out  PIXELS_PER_WORD  per-pixel lane enable
- addr  out  ADDRESS_WIDTH  {bank, word index}
- o_data  out  DATA_WIDTH  packed word
- line_irq  out  1  one-cycle pulse: a line is complete in line_bank
- line_bank  out  1  bank of the last completed line
- line_words  out  ADDRESS_WIDTH  words written for that line (1..BANK_WORDS)
- bank_full  out  2  per-bank full flags
- frame_start  out  1  one-cycle pulse on vsync rising edge
- overflow  out  1  sticky: a line was dropped because the write bank was full
- truncated  out  1  sticky: a line exceeded BANK_WORDS

## Operation
- Reset: every output is 0, wr_bank=0, rd_bank=0, lane count=0, FSM=IDLE.
- FSM states: IDLE, FILL, DROP, FLUSH.
- IDLE→FILL: vde=1 and bank_full[wr_bank]=0. The pixel is captured in that same cycle.
- IDLE→DROP: vde=1 and bank_full[wr_bank]=1. overflow<=1. No writes and no irq for that line.
- DROP→IDLE: vde=0.
- FILL: the first pixel of each word goes in the most significant lane, later pixels in successively lower lanes.
- FILL, word complete: when lane PIXELS_PER_WORD-1 fills, the block writes the word with be=all ones at addr={wr_bank, word_idx}, then increments word_idx.
- FILL, bank capacity: once word_idx has reached BANK_WORDS, further words are discarded and truncated<=1. word_idx saturates.
- FILL→FLUSH: vde=0.
- FLUSH, partial word pending: the block writes it. Filled lanes have be=1; unfilled lanes have be=0 and data 0.
- FLUSH, completion (same cycle as the flush write):
  - bank_full[wr_bank]<=1
  - line_bank<=wr_bank
  - line_words<=word count, including the partial word
  - toggle wr_bank, clear word_idx and lane count
  - go to IDLE
- line_irq is asserted the cycle after FLUSH.
- line_ack with any bank full: clears bank_full[rd_bank] and toggles rd_bank.
- line_ack with no bank full: ignored.
- line_ack and FLUSH completion in the same cycle: both take effect. A clear and a set of the same bank cannot coincide.
- vsync rising edge: frame_start pulse, clears overflow and truncated. It does not alter banks or the FSM.
- A vde rise in the cycle directly after FLUSH is legal and starts the next line normally.
- Asynchronous reset mid-line: aborts immediately and returns all state to reset values.

## Timing
- All outputs are registered.
- Write latency: the pixel completing a word, sampled at edge N, gives we/addr/o_data/be valid after edge N+1 for exactly one cycle.
- The flush write follows the edge sampling vde=0 by one cycle. line_irq follows it by one more cycle. line_bank and line_words are stable from line_irq until the next completion.
- we is never high in two consecutive cycles unless PIXELS_PER_WORD=1.
- frame_start is valid one cycle after the edge sampling the vsync 0→1 transition.
- Maximum sustained rate is one pixel per clock. There is no backpressure on the pixel side.

## Test plan
All cases use PIXEL_WIDTH=8, PIXELS_PER_WORD=4, ADDRESS_WIDTH=4, so BANK_WORDS=8.
- Reset check: drive reset_n=0 mid-FILL -> all outputs 0 immediately; the next line writes to bank 0, addr 0.
- Exact fill: 8 pixels 0x01..0x08 on vde, no acks -> two writes:
  - addr=0x0, o_data=0x01020304, be=0xF
  - addr=0x1, o_data=0x05060708, be=0xF
  - then line_irq, line_bank=0, line_words=2, bank_full=01.
- Partial flush: 6 pixels 0xA0..0xA5 -> two writes:
  - o_data=0xA0A1A2A3, be=0xF
  - o_data=0xA4A50000, be=0xC, addr=0x1
  - then line_words=2.
- Ping-pong and overflow: three lines with no line_ack ->
  - line 1 goes to bank 0 (addr 0x0..), line 2 to bank 1 (addr 0x8..)
  - line 3: no we, no irq, overflow=1
  - vsync rise -> frame_start pulse, overflow=0.
- Ack ordering: after both banks are full, pulse line_ack -> bank_full=10; the next line writes bank 0 and irqs with line_bank=0. Also, line_ack in the same cycle as a FLUSH completion -> both applied.
- Truncation: 40-pixel line -> exactly 8 writes (addr 0x0..0x7), truncated=1, line_words=8.
